// File: rtl/lector_display_7seg_pkg.sv
// Shared definitions for the 7-segment display reader: segment patterns, blank pattern, FSM states.
// Latency: none (constants and types only).
// Backpressure: not applicable.
//
// Segment patterns are {a,b,c,d,e,f,g}, bit 6 = a, active-low (0 = segment lit).
// These are the same constants the binary-to-7-segment decoder drives.
package paquete_7seg;

    localparam logic [6:0] SEG_0      = 7'h01;
    localparam logic [6:0] SEG_1      = 7'h4F;
    localparam logic [6:0] SEG_2      = 7'h12;
    localparam logic [6:0] SEG_3      = 7'h06;
    localparam logic [6:0] SEG_4      = 7'h4C;
    localparam logic [6:0] SEG_5      = 7'h24;
    localparam logic [6:0] SEG_6      = 7'h20;
    localparam logic [6:0] SEG_7      = 7'h0F;
    localparam logic [6:0] SEG_8      = 7'h00;
    localparam logic [6:0] SEG_9      = 7'h0C;
    localparam logic [6:0] SEG_A      = 7'h08;
    localparam logic [6:0] SEG_B      = 7'h60;
    localparam logic [6:0] SEG_C      = 7'h31;
    localparam logic [6:0] SEG_D      = 7'h42;
    localparam logic [6:0] SEG_E      = 7'h30;
    localparam logic [6:0] SEG_F      = 7'h38;
    localparam logic [6:0] SEG_BLANCO = 7'h7F;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        RECOGE  = 2'd1,
        PUBLICA = 2'd2
    } estado_t;

endpackage

// File: rtl/lector_display_7seg_if.sv
// Bus between the display-sniffing pins / consumer logic and the 7-segment reader.
// Latency: none (wires only).
// Backpressure: none; o_Valido / o_Error are single-cycle pulses the consumer must take.
//
// Ports: i_Segmentos (7, active-low segments), i_Digitos (N_DIGITOS, active-low enables),
// i_Habilitar (capture enable), o_Valor (4*N_DIGITOS), o_Valido, o_Error, o_Invalidos (N_DIGITOS).
// master = the side driving the pins and reading results; slave = the reader itself.
interface lector_display_7seg_if #(
    parameter int N_DIGITOS = 4
);
    logic [6:0]             i_Segmentos;
    logic [N_DIGITOS-1:0]   i_Digitos;
    logic                   i_Habilitar;
    logic [4*N_DIGITOS-1:0] o_Valor;
    logic                   o_Valido;
    logic                   o_Error;
    logic [N_DIGITOS-1:0]   o_Invalidos;

    modport master (
        output i_Segmentos, i_Digitos, i_Habilitar,
        input  o_Valor, o_Valido, o_Error, o_Invalidos
    );

    modport slave (
        input  i_Segmentos, i_Digitos, i_Habilitar,
        output o_Valor, o_Valido, o_Error, o_Invalidos
    );
endinterface

// File: rtl/lector_display_7seg_codificador.sv
// Converts one active-low 7-segment pattern back to a hex nibble, flagging unknown patterns.
// Latency: combinational.
// Backpressure: none.
//
// Ports: patron (7, in), nibble (4, out), invalido (1, out).
// Unknown patterns, including blank, give nibble 0 with invalido set.
module codificador_7seg_binario
    import paquete_7seg::*;
(
    input  logic [6:0] patron,
    output logic [3:0] nibble,
    output logic       invalido
);
    always_comb begin
        nibble   = 4'h0;
        invalido = 1'b0;
        case (patron)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: invalido = 1'b1;
        endcase
    end
endmodule

// File: rtl/lector_display_7seg.sv
// Reads a multiplexed common-anode 7-segment display back into an N-digit binary value.
// Latency: pattern steady from edge t captured at t+2+ESTABLE; o_Valido one cycle after the completing capture.
// Backpressure: none; results are one-cycle pulses, o_Valor holds the last completed frame.
//
// Ports: i_Clk, i_Reset_n (async, active-low), bus (slave modport: pins in, o_Valor/o_Valido/o_Error/o_Invalidos out).
module lector_display_7seg
    import paquete_7seg::*;
#(
    parameter int N_DIGITOS = 4,
    parameter int ESTABLE   = 4,
    parameter int TIMEOUT   = 65536
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    lector_display_7seg_if.slave  bus
);
    localparam int AN_EST = $clog2(ESTABLE + 1);
    localparam int AN_TO  = $clog2(TIMEOUT);
    localparam logic [AN_EST-1:0] EST_ULT = AN_EST'(ESTABLE - 1);
    localparam logic [AN_EST-1:0] EST_MAX = AN_EST'(ESTABLE);
    localparam logic [AN_TO-1:0]  TO_ULT  = AN_TO'(TIMEOUT - 1);

    logic [6:0]             seg_m, seg_s, seg_prev;
    logic [N_DIGITOS-1:0]   dig_m, dig_s, dig_prev;
    logic [AN_EST-1:0]      cnt_est;
    logic                   armado;
    logic                   cambio, un_solo, captura;
    logic [N_DIGITOS-1:0]   activo;
    logic [3:0]             nibble;
    logic                   invalido;

    estado_t                estado;
    logic [AN_TO-1:0]       cnt_trama;
    logic [4*N_DIGITOS-1:0] sombra, sombra_act, sombra_limpia;
    logic [N_DIGITOS-1:0]   inv_sh, inv_act, inv_limpia;
    logic [N_DIGITOS-1:0]   mascara, mascara_act, mascara_limpia;

    assign activo  = ~dig_s;
    assign cambio  = (seg_s != seg_prev) || (dig_s != dig_prev);
    assign un_solo = (activo != '0) && ((activo & (activo - 1'b1)) == '0);
    // Fires on the edge where the stability count reaches ESTABLE, so each
    // stable activation yields at most one capture; armado guards re-entry.
    assign captura = !cambio && (cnt_est == EST_ULT) && un_solo && armado;

    // Synchronizers reset to all ones so the reader starts with nothing lit and no digit enabled.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            seg_m    <= '1;
            seg_s    <= '1;
            seg_prev <= '1;
            dig_m    <= '1;
            dig_s    <= '1;
            dig_prev <= '1;
            cnt_est  <= '0;
            armado   <= 1'b0;
        end else begin
            seg_m    <= bus.i_Segmentos;
            seg_s    <= seg_m;
            seg_prev <= seg_s;
            dig_m    <= bus.i_Digitos;
            dig_s    <= dig_m;
            dig_prev <= dig_s;
            if (cambio) begin
                cnt_est <= '0;
                armado  <= 1'b1;
            end else begin
                if (cnt_est != EST_MAX) begin
                    cnt_est <= cnt_est + 1'b1;
                end
                if (captura) begin
                    armado <= 1'b0;
                end
            end
        end
    end

    codificador_7seg_binario u_codificador (
        .patron   (seg_s),
        .nibble   (nibble),
        .invalido (invalido)
    );

    // "_act" keeps the current frame and adds this cycle's capture;
    // "_limpia" starts a new frame but still keeps a capture landing on the same edge.
    always_comb begin
        sombra_act     = sombra;
        inv_act        = inv_sh;
        mascara_act    = mascara;
        sombra_limpia  = '0;
        inv_limpia     = '0;
        mascara_limpia = '0;
        for (int k = 0; k < N_DIGITOS; k++) begin
            if (captura && activo[k]) begin
                sombra_act[4*k +: 4]    = nibble;
                sombra_limpia[4*k +: 4] = nibble;
                inv_act[k]              = invalido;
                inv_limpia[k]           = invalido;
                mascara_act[k]          = 1'b1;
                mascara_limpia[k]       = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            estado          <= REPOSO;
            cnt_trama       <= '0;
            sombra          <= '0;
            inv_sh          <= '0;
            mascara         <= '0;
            bus.o_Valor     <= '0;
            bus.o_Valido    <= 1'b0;
            bus.o_Error     <= 1'b0;
            bus.o_Invalidos <= '0;
        end else begin
            bus.o_Valido <= 1'b0;
            bus.o_Error  <= 1'b0;
            case (estado)
                REPOSO: begin
                    sombra    <= '0;
                    inv_sh    <= '0;
                    mascara   <= '0;
                    cnt_trama <= '0;
                    if (bus.i_Habilitar) begin
                        estado <= RECOGE;
                    end
                end
                RECOGE: begin
                    if (&mascara) begin
                        estado          <= PUBLICA;
                        bus.o_Valor     <= sombra;
                        bus.o_Invalidos <= inv_sh;
                        bus.o_Valido    <= 1'b1;
                        bus.o_Error     <= |inv_sh;
                        sombra          <= sombra_limpia;
                        inv_sh          <= inv_limpia;
                        mascara         <= mascara_limpia;
                    end else if (!bus.i_Habilitar) begin
                        // Partial frame is dropped silently.
                        estado    <= REPOSO;
                        sombra    <= '0;
                        inv_sh    <= '0;
                        mascara   <= '0;
                        cnt_trama <= '0;
                    end else if (cnt_trama == TO_ULT) begin
                        bus.o_Error <= 1'b1;
                        cnt_trama   <= '0;
                        sombra      <= sombra_limpia;
                        inv_sh      <= inv_limpia;
                        mascara     <= mascara_limpia;
                    end else begin
                        cnt_trama <= cnt_trama + 1'b1;
                        sombra    <= sombra_act;
                        inv_sh    <= inv_act;
                        mascara   <= mascara_act;
                    end
                end
                PUBLICA: begin
                    estado    <= RECOGE;
                    cnt_trama <= '0;
                    sombra    <= sombra_act;
                    inv_sh    <= inv_act;
                    mascara   <= mascara_act;
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lector_display_7seg.sv
// Self-checking bench for lector_display_7seg: directed frames plus randomized display traffic.
// Expected pulses come from an event-level model: per-activation capture times, frame assembly, timeouts.
// Every output pulse (expected or observed) is compared cycle by cycle.
module tb_lector_display_7seg;
    localparam int N = 4;
    localparam int E = 4;
    localparam int T = 300;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lector_display_7seg_if #(.N_DIGITOS(N)) bus ();

    lector_display_7seg #(
        .N_DIGITOS (N),
        .ESTABLE   (E),
        .TIMEOUT   (T)
    ) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .bus       (bus)
    );

    // Display patterns indexed by the hex value they show.
    logic [6:0] TABLA [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_err   = 0;
    logic hab_e = 1'b0;
    logic rst_e = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void ref_decode(input logic [6:0] p, output logic [3:0] n, output bit inv);
        n   = 4'h0;
        inv = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (TABLA[i] == p) begin
                n   = 4'(i);
                inv = 1'b0;
            end
        end
    endfunction

    function automatic int digito_activo(input logic [3:0] dig);
        int cuenta = 0;
        int idx    = -1;
        for (int i = 0; i < N; i++) begin
            if (!dig[i]) begin
                cuenta++;
                idx = i;
            end
        end
        return (cuenta == 1) ? idx : -1;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int         cyc;
        int         dig;
        logic [6:0] seg;
    } cap_t;
    cap_t sched[$];

    bit          colectando = 1'b0;
    bit          entrando;
    int          fs = 0;
    int          pub_cyc = -1;
    logic [15:0] m_sombra = '0;
    logic [3:0]  m_inv = '0;
    logic [3:0]  m_mask = '0;
    logic [15:0] m_valor = '0;
    logic [3:0]  exp_inv;
    bit          ev, ee;
    logic [3:0]  r_nib;
    bit          r_inv;
    cap_t        c;

    always @(posedge clk) begin
        cyc   = cyc + 1;
        hab_e = bus.i_Habilitar;
        rst_e = rst_n;
    end

    always @(negedge clk) begin
        ev = 1'b0;
        ee = 1'b0;
        entrando = 1'b0;
        if (!rst_e) begin
            colectando = 1'b0;
            pub_cyc    = -1;
            m_sombra   = '0;
            m_inv      = '0;
            m_mask     = '0;
            m_valor    = '0;
            sched.delete();
            check_eq("rst_valor", bus.o_Valor, 0);
            check_eq("rst_valido", bus.o_Valido, 0);
            check_eq("rst_error", bus.o_Error, 0);
            check_eq("rst_invalidos", bus.o_Invalidos, 0);
        end else begin
            if (!colectando) begin
                if (hab_e) begin
                    colectando = 1'b1;
                    entrando   = 1'b1;
                    fs         = cyc;
                end
            end else if (pub_cyc == cyc) begin
                ev       = 1'b1;
                m_valor  = m_sombra;
                exp_inv  = m_inv;
                ee       = |m_inv;
                m_sombra = '0; m_inv = '0; m_mask = '0;
                fs       = cyc + 1;
                pub_cyc  = -1;
            end else if (!hab_e) begin
                colectando = 1'b0;
                m_sombra = '0; m_inv = '0; m_mask = '0;
            end else if (fs + T == cyc) begin
                ee = 1'b1;
                fs = cyc;
                m_sombra = '0; m_inv = '0; m_mask = '0;
            end
            while (sched.size() > 0 && sched[0].cyc <= cyc) begin
                c = sched.pop_front();
                if (c.cyc == cyc && colectando && !entrando) begin
                    ref_decode(c.seg, r_nib, r_inv);
                    m_sombra[4*c.dig +: 4] = r_nib;
                    m_inv[c.dig]  = r_inv;
                    m_mask[c.dig] = 1'b1;
                    if (m_mask == 4'hF && pub_cyc < 0) pub_cyc = cyc + 1;
                end
            end
            if (bus.o_Valido || ev) check_eq("valido", bus.o_Valido, ev);
            if (bus.o_Error || ee) check_eq("error", bus.o_Error, ee);
            if (ev) begin
                check_eq("valor", bus.o_Valor, m_valor);
                check_eq("invalidos", bus.o_Invalidos, exp_inv);
            end else if (ee) begin
                check_eq("valor_retenido", bus.o_Valor, m_valor);
            end
            if (bus.o_Valido) n_valid++;
            if (bus.o_Error)  n_err++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic mostrar(input logic [6:0] seg, input logic [3:0] dig, input int hold);
        int d;
        @(negedge clk);
        bus.i_Segmentos = seg;
        bus.i_Digitos   = dig;
        d = digito_activo(dig);
        // Sampled first at the next edge, seen settled after two more, then ESTABLE equal samples.
        if (d >= 0 && hold >= E + 1) sched.push_back('{cyc + 1 + 2 + E, d, seg});
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic gap(input int n);
        mostrar(7'h7F, 4'hF, n);
    endtask

    task automatic mostrar_digito(input int k, input logic [6:0] seg, input int hold);
        logic [3:0] dig;
        dig = ~(4'b0001 << k);
        mostrar(seg, dig, hold);
    endtask

    task automatic trama(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0);
        mostrar_digito(3, p3, 8); gap(2);
        mostrar_digito(2, p2, 8); gap(2);
        mostrar_digito(1, p1, 8); gap(2);
        mostrar_digito(0, p0, 8); gap(6);
    endtask

    int perm [4];
    int v0, e0, tmp, j, d;
    logic [6:0] p;

    initial begin
        bus.i_Segmentos = 7'h7F;
        bus.i_Digitos   = 4'hF;
        bus.i_Habilitar = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("post_rst_valor", bus.o_Valor, 0);
        check_eq("post_rst_invalidos", bus.o_Invalidos, 0);
        bus.i_Habilitar = 1'b1;

        // Basic frame 0x0123.
        trama(7'h01, 7'h4F, 7'h12, 7'h06);
        check_eq("t1_valor", bus.o_Valor, 16'h0123);
        check_eq("t1_invalidos", bus.o_Invalidos, 4'b0000);

        // Blank digit 2 -> invalid bit, value 0 in that slot.
        trama(7'h01, 7'h7F, 7'h12, 7'h06);
        check_eq("t2_valor", bus.o_Valor, 16'h0023);
        check_eq("t2_invalidos", bus.o_Invalidos, 4'b0100);

        // Too-short holds and ghosting never capture; frame times out.
        e0 = n_err;
        v0 = n_valid;
        for (int k = 0; k < 4; k++) begin
            mostrar_digito(k, TABLA[k+4], E - 1); gap(2);
        end
        mostrar(7'h06, 4'b0011, 12); gap(2);
        mostrar(7'h12, 4'b0000, 12); gap(T);
        check_eq("t3_timeout_pulsos", n_err - e0, 1);
        check_eq("t3_sin_valido", n_valid - v0, 0);
        check_eq("t3_valor_retenido", bus.o_Valor, 16'h0023);

        // Latest wins on digit 0.
        mostrar_digito(0, 7'h38, 8); gap(2);
        mostrar_digito(0, 7'h30, 8); gap(2);
        mostrar_digito(1, 7'h4C, 8); gap(2);
        mostrar_digito(2, 7'h24, 8); gap(2);
        mostrar_digito(3, 7'h20, 8); gap(6);
        check_eq("t4_valor", bus.o_Valor, 16'h654E);

        // One long activation completes a frame and must not seed the next one.
        mostrar_digito(3, 7'h0F, 8); gap(2);
        mostrar_digito(2, 7'h00, 8); gap(2);
        mostrar_digito(1, 7'h0C, 8); gap(2);
        mostrar_digito(0, 7'h06, 40); gap(2);
        check_eq("t5_valor", bus.o_Valor, 16'h7893);
        v0 = n_valid;
        mostrar_digito(3, 7'h0F, 8); gap(2);
        mostrar_digito(2, 7'h00, 8); gap(2);
        mostrar_digito(1, 7'h0C, 8); gap(10);
        check_eq("t5_una_captura", n_valid - v0, 0);

        // Enable dropped mid-frame.
        mostrar_digito(3, 7'h4F, 8); gap(2);
        mostrar_digito(2, 7'h4F, 8); gap(4);
        v0 = n_valid;
        @(negedge clk); bus.i_Habilitar = 1'b0;
        repeat (5) @(negedge clk);
        bus.i_Habilitar = 1'b1;
        check_eq("t6_sin_pulso", n_valid - v0, 0);
        trama(7'h00, 7'h0C, 7'h08, 7'h60);
        check_eq("t6_valor", bus.o_Valor, 16'h89AB);

        // Reset mid-frame.
        mostrar_digito(3, 7'h12, 8); gap(2);
        mostrar_digito(2, 7'h12, 8); gap(E + 4);
        @(negedge clk); rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t7_rst_valor", bus.o_Valor, 0);
        check_eq("t7_rst_valido", bus.o_Valido, 0);
        rst_n = 1'b1;
        trama(7'h31, 7'h42, 7'h30, 7'h38);
        check_eq("t7_valor", bus.o_Valor, 16'hCDEF);

        // Randomized traffic with noise, recaptures and invalid patterns.
        for (int f = 0; f < 25; f++) begin
            perm = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
            end
            for (int i = 0; i < 6; i++) begin
                d = (i < 4) ? perm[i] : $urandom_range(0, 3);
                if ($urandom_range(0, 9) == 0) p = 7'($urandom_range(0, 127));
                else p = TABLA[$urandom_range(0, 15)];
                if ($urandom_range(0, 3) == 0) begin
                    mostrar(7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), $urandom_range(1, E - 1));
                end
                gap($urandom_range(1, 3));
                mostrar_digito(d, p, $urandom_range(E + 2, 10));
            end
        end
        gap(20);
        check_eq("final_valor", bus.o_Valor, m_valor);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lector_display_7seg.md
# lector_display_7seg

Captures the multiplexed 7-segment display lines of an external board (segments plus digit enables, active-low, common-anode) and converts them back to binary. It performs the reverse of the team's binary-to-7-segment decoder. It synchronises and debounces the lines, decodes each stable digit pattern to a hex nibble, and publishes a complete N-digit value with a one-cycle valid pulse. It sits between the display-sniffing input pins and the measurement/logging logic.

## Interface
- N_DIGITOS, 4: number of multiplexed digits; o_Valor is 4*N_DIGITOS bits.
- ESTABLE, 4: consecutive identical synchronized samples required before a digit is captured (≥2).
- TIMEOUT, 65536: cycles allowed to complete one frame before it is aborted.
- i_Clk  in  1  system clock; all logic on its rising edge.
- i_Reset_n  in  1  reset, asynchronous and active-low.
- i_Segmentos  in  7  segment lines {a,b,c,d,e,f,g}, bit 6 = a, 0 = lit; asynchronous to i_Clk.
- i_Digitos  in  N_DIGITOS  digit enables, 0 = digit active; bit 0 = least significant digit; asynchronous.
- i_Habilitar  in  1  capture enable, synchronous.
- o_Valor  out  4*N_DIGITOS  last completed frame, digit k in bits [4k+3:4k].
- o_Valido  out  1  one-cycle pulse when o_Valor is updated.
- o_Error  out  1  one-cycle pulse: frame contained an invalid pattern, or timeout.
- o_Invalidos  out  N_DIGITOS  per-digit invalid-pattern mask of the last published frame.

## Operation
- Two-flop synchronizer on i_Segmentos and i_Digitos; everything downstream uses synchronized values only.
- Stability: counter increments while the synced {seg,dig} equals the previous sample and saturates at ESTABLE. It clears on any change.
- Capture condition: counter reaches ESTABLE, exactly one i_Digitos bit is low, and the armed flag is set. The armed flag clears at capture and re-arms on any change of the synced pattern, so there is one capture per digit activation.
- Zero or multiple active enables never capture (ghosting/blanking interval).
- Decode map (pattern→nibble): 0x01→0, 0x4F→1, 0x12→2, 0x06→3, 0x4C→4, 0x24→5, 0x20→6, 0x0F→7, 0x00→8, 0x0C→9, 0x08→A, 0x60→b, 0x31→C, 0x42→d, 0x30→E, 0x38→F.
- Any other pattern, including blank 0x7F, decodes to nibble 0 and sets that digit's bit in the shadow invalid mask.
- Captures go into a shadow register and a captured-mask. Recapturing a digit before frame completion overwrites it (latest wins).
- FSM states:
  - REPOSO: i_Habilitar=0, shadow/mask cleared. Goes to RECOGE when i_Habilitar=1.
  - RECOGE: collects captures. Goes to PUBLICA when the captured-mask is all ones. Goes to REPOSO when i_Habilitar falls; no outputs change and the partial frame is discarded.
  - PUBLICA: lasts one cycle. o_Valor←shadow, o_Invalidos←shadow mask, o_Valido=1, o_Error=1 if any invalid bit. Clears the mask, then returns to RECOGE.
- Timeout: a frame counter runs in RECOGE and resets on entering RECOGE. If it reaches TIMEOUT-1, o_Error pulses, o_Valido stays 0, the mask/shadow clear, o_Valor is held, and a new frame starts.
- A capture in the PUBLICA cycle counts toward the next frame.

## Timing
- Reset values: o_Valor=0, o_Valido=0, o_Error=0, o_Invalidos=0, FSM=REPOSO, synchronizers=all ones (inactive), counters=0.
- Latency: a pattern steady at the pins from edge t is captured at edge t+2+ESTABLE. If it completes the frame, o_Valido is high in the cycle following that capture.
- o_Valido and o_Error are exactly one cycle wide and may coincide.
- Reset mid-frame: all state returns to reset values immediately; no pulse is emitted.

## Structure
- Package paquete_7seg: the 16 segment-pattern constants (shared with the existing binary-to-7-segment decoder), the blank constant 0x7F, and the FSM state enum.
- Sub-module codificador_7seg_binario (combinational): 7-bit pattern in → 4-bit nibble plus invalid flag out. It is reusable by other readers.

## Test plan
- Reset, then drive digits 3,2,1,0 with 0x01,0x4F,0x12,0x06, 8 cycles each, ESTABLE=4 → one o_Valido pulse, o_Valor=0x0123, o_Invalidos=0, no o_Error.
- Same frame with digit 2 = 0x7F → o_Valor=0x0023, o_Invalidos=0b0100, o_Valido and o_Error in the same cycle.
- Patterns held only ESTABLE-1 cycles, or two enables low at once → no capture; after TIMEOUT cycles o_Error pulses, o_Valor unchanged.
- Digit 0 shown as 0x38 then as 0x30 before the other digits appear → published nibble 0 = E (latest wins); a single held activation never captures twice.
- i_Habilitar dropped mid-frame, or i_Reset_n pulsed low mid-frame → no pulses; the next full frame publishes correctly. After reset, all outputs are 0.
